// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the requesters, the shared pipelined ALU and alu_share_arbiter.
// The arbiter uses the slave modport; the requester/ALU side uses master.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_funct;
  logic [16*NUM_REQ-1:0] req_x;
  logic [16*NUM_REQ-1:0] req_y;
  logic [16*NUM_REQ-1:0] req_mask;
  logic [NUM_REQ-1:0]    req_carry;
  logic [NUM_REQ-1:0]    req_select;

  logic [15:0]           alu_x;
  logic [15:0]           alu_y;
  logic [15:0]           alu_mask;
  logic [3:0]            alu_funct;
  logic                  alu_carry;
  logic                  alu_select;
  logic                  alu_valid_in;
  logic [15:0]           alu_out;
  logic [31:0]           alu_mul_out;
  logic                  alu_carry_out;
  logic                  alu_valid_out;

  logic [NUM_REQ-1:0]    resp_valid;
  logic [15:0]           resp_result;
  logic [31:0]           resp_mul;
  logic                  resp_carry;

  modport slave (
    input  req_valid, req_funct, req_x, req_y, req_mask, req_carry, req_select,
    output req_ready,
    output alu_x, alu_y, alu_mask, alu_funct, alu_carry, alu_select, alu_valid_in,
    input  alu_out, alu_mul_out, alu_carry_out, alu_valid_out,
    output resp_valid, resp_result, resp_mul, resp_carry
  );

  modport master (
    output req_valid, req_funct, req_x, req_y, req_mask, req_carry, req_select,
    input  req_ready,
    input  alu_x, alu_y, alu_mask, alu_funct, alu_carry, alu_select, alu_valid_in,
    output alu_out, alu_mul_out, alu_carry_out, alu_valid_out,
    input  resp_valid, resp_result, resp_mul, resp_carry
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined ALU among NUM_REQ requesters,
// with drain/idle quiescing. Define ALU_ARB_ERR_CHECK_EN to build the sticky tag/valid check.
module alu_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  alu_share_arbiter_if.slave    bus,
  input  logic                  drain,
  output logic                  idle,
  output logic                  err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(ALU_LATENCY + 2);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [NUM_REQ-1:0] grant;
  logic            found;
  logic            accept;
  logic            hs;
  logic [CW-1:0]   inflight;
  logic            drained;

  logic [15:0]     alu_x_p0, alu_y_p0, alu_mask_p0;
  logic [3:0]      alu_funct_p0;
  logic            alu_carry_p0, alu_select_p0;
  logic            vld_p0;
  logic [IW-1:0]   idx_p0;

  logic            tag_vld_p [ALU_LATENCY];
  logic [IW-1:0]   tag_idx_p [ALU_LATENCY];
  logic            tail_vld;
  logic [IW-1:0]   tail_idx;

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[IW'(idx)]) begin
        found             = 1'b1;
        win_idx           = IW'(idx);
        grant[IW'(idx)]   = 1'b1;
      end
    end
  end

  assign accept        = (state == ST_RUN) && !drain;
  assign bus.req_ready = accept ? grant : '0;
  assign hs            = accept && found;

  assign tail_vld = tag_vld_p[ALU_LATENCY-1];
  assign tail_idx = tag_idx_p[ALU_LATENCY-1];
  // The retiring tail op counts as already gone so idle rises the cycle after the last response.
  assign drained  = (inflight == CW'(tail_vld));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (drain) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!drain) state_nxt = ST_RUN;
                else if (drained) state_nxt = ST_IDLE;
      ST_IDLE:  if (!drain) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign idle = (state == ST_IDLE);

  // Stage p0: issue register driving the ALU
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_RUN;
      rr_ptr        <= '0;
      inflight      <= '0;
      vld_p0        <= 1'b0;
      idx_p0        <= '0;
      alu_x_p0      <= '0;
      alu_y_p0      <= '0;
      alu_mask_p0   <= '0;
      alu_funct_p0  <= '0;
      alu_carry_p0  <= 1'b0;
      alu_select_p0 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= hs;
      if (hs) begin
        rr_ptr        <= IW'((int'(win_idx) + 1) % NUM_REQ);
        idx_p0        <= win_idx;
        alu_x_p0      <= bus.req_x[16*int'(win_idx) +: 16];
        alu_y_p0      <= bus.req_y[16*int'(win_idx) +: 16];
        alu_mask_p0   <= bus.req_mask[16*int'(win_idx) +: 16];
        alu_funct_p0  <= bus.req_funct[4*int'(win_idx) +: 4];
        alu_carry_p0  <= bus.req_carry[win_idx];
        alu_select_p0 <= bus.req_select[win_idx];
      end
      case ({hs, tail_vld})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign bus.alu_x        = alu_x_p0;
  assign bus.alu_y        = alu_y_p0;
  assign bus.alu_mask     = alu_mask_p0;
  assign bus.alu_funct    = alu_funct_p0;
  assign bus.alu_carry    = alu_carry_p0;
  assign bus.alu_select   = alu_select_p0;
  assign bus.alu_valid_in = vld_p0;

  // Stages p1..pL: tag pipeline tracking the ALU's own latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < ALU_LATENCY; s++) begin
        tag_vld_p[s] <= 1'b0;
        tag_idx_p[s] <= '0;
      end
    end else begin
      tag_vld_p[0] <= vld_p0;
      tag_idx_p[0] <= idx_p0;
      for (int s = 1; s < ALU_LATENCY; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_idx_p[s] <= tag_idx_p[s-1];
      end
    end
  end

  always_comb begin
    bus.resp_valid = '0;
    if (tail_vld) bus.resp_valid[tail_idx] = 1'b1;
  end

  assign bus.resp_result = bus.alu_out;
  assign bus.resp_mul    = bus.alu_mul_out;
  assign bus.resp_carry  = bus.alu_carry_out;

`ifdef ALU_ARB_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if (bus.alu_valid_out != tail_vld) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_alu_valid_out;
  assign unused_alu_valid_out = bus.alu_valid_out;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 3-cycle ALU stub.
module tb_alu_share_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_MUL  = 4'd2;
  localparam logic [3:0] F_ADDC = 4'd15;
`ifdef ALU_ARB_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic drain  = 1'b0;
  logic inject = 1'b0;
  logic idle, err;
  int   tests = 0;
  int   fails = 0;
  int   n1, n3;
  int   rr_seq [5] = '{3, 0, 1, 2, 3};
  int   dr_seq [3] = '{2, 3, 0};

  alu_share_arbiter_if #(.NUM_REQ(NR)) bus ();

  alu_share_arbiter #(.NUM_REQ(NR), .ALU_LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .drain (drain),
    .idle  (idle),
    .err   (err)
  );

  always #5 clock = ~clock;

  // ALU stub: ADD, ADDC, MUL with a fixed LAT-cycle pipeline
  logic [15:0] f_out;
  logic [31:0] f_mul;
  logic        f_c;
  logic [15:0] st_out [LAT];
  logic [31:0] st_mul [LAT];
  logic        st_c   [LAT];
  logic        st_v   [LAT];

  always_comb begin
    f_mul        = 32'(bus.alu_x) * 32'(bus.alu_y);
    {f_c, f_out} = 17'(bus.alu_x) + 17'(bus.alu_y);
    if (bus.alu_funct == F_ADDC)
      {f_c, f_out} = 17'(bus.alu_x) + 17'(bus.alu_y) + 17'(bus.alu_carry);
    else if (bus.alu_funct == F_MUL) begin
      f_out = f_mul[15:0];
      f_c   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    st_out[0] <= f_out;
    st_mul[0] <= f_mul;
    st_c[0]   <= f_c;
    st_v[0]   <= bus.alu_valid_in;
    for (int s = 1; s < LAT; s++) begin
      st_out[s] <= st_out[s-1];
      st_mul[s] <= st_mul[s-1];
      st_c[s]   <= st_c[s-1];
      st_v[s]   <= st_v[s-1];
    end
  end

  assign bus.alu_out       = st_out[LAT-1];
  assign bus.alu_mul_out   = st_mul[LAT-1];
  assign bus.alu_carry_out = st_c[LAT-1];
  assign bus.alu_valid_out = st_v[LAT-1] | inject;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] f, input logic [15:0] x,
                         input logic [15:0] y, input logic c);
    bus.req_funct[4*i +: 4] = f;
    bus.req_x[16*i +: 16]   = x;
    bus.req_y[16*i +: 16]   = y;
    bus.req_carry[2'(i)]    = c;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_funct  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_mask   = '0;
    bus.req_carry  = '0;
    bus.req_select = '0;
    n1 = 0;
    n3 = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready",    32'(bus.req_ready),    32'h0);
    chk("rst_valid_in", 32'(bus.alu_valid_in), 32'h0);
    chk("rst_alu_x",    32'(bus.alu_x),        32'h0);
    chk("rst_funct",    32'(bus.alu_funct),    32'h0);
    chk("rst_resp",     32'(bus.resp_valid),   32'h0);
    chk("rst_idle",     32'(idle),             32'h0);
    chk("rst_err",      32'(err),              32'h0);
    reset = 1'b1;
    tick();

    // Single op from requester 2: ADD 0x1234 + 0x0001
    set_req(2, F_ADD, 16'h1234, 16'h0001, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    chk("t1_valid_in", 32'(bus.alu_valid_in), 32'h1);
    chk("t1_alu_x",    32'(bus.alu_x),        32'h1234);
    chk("t1_alu_y",    32'(bus.alu_y),        32'h0001);
    tick();
    chk("t1_resp_early2", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("t1_resp_early3", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("t1_resp_vld", 32'(bus.resp_valid),  32'h4);
    chk("t1_resp_res", 32'(bus.resp_result), 32'h1235);
    tick();
    chk("t1_resp_after", 32'(bus.resp_valid), 32'h0);

    // All four requesters valid, rr_ptr starts at 3
    for (int i = 0; i < NR; i++) set_req(i, F_ADD, 16'((i + 1) * 4096), 16'(i), 1'b0);
    for (int c = 0; c < 9; c++) begin
      bus.req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      if (c < 5) chk("t2_grant", 32'(bus.req_ready), 32'(1 << rr_seq[c]));
      if (c >= 4) begin
        chk("t2_resp_vld", 32'(bus.resp_valid),  32'(1 << rr_seq[c-4]));
        chk("t2_resp_res", 32'(bus.resp_result), 32'((rr_seq[c-4] + 1) * 4096 + rr_seq[c-4]));
      end
      tick();
    end

    // Requesters 1 and 3 after last winner 1: alternate 3,1,... without starvation
    bus.req_valid = 4'b0010;
    #1;
    chk("t3_prime", 32'(bus.req_ready), 32'h2);
    tick();
    for (int c = 0; c < 100; c++) begin
      bus.req_valid = 4'b1010;
      #1;
      chk("t3_grant", 32'(bus.req_ready), (c % 2 == 0) ? 32'h8 : 32'h2);
      if (bus.req_ready == 4'b0010) n1++;
      if (bus.req_ready == 4'b1000) n3++;
      tick();
    end
    chk("t3_cnt1", 32'(n1), 32'd50);
    chk("t3_cnt3", 32'(n3), 32'd50);
    bus.req_valid = 4'b0000;
    repeat (5) tick();

    // Drain with three ops in flight (rr_ptr = 2)
    bus.req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_grant", 32'(bus.req_ready), 32'(1 << dr_seq[c]));
      tick();
    end
    drain = 1'b1;
    #1;
    chk("t4_ready_drain", 32'(bus.req_ready), 32'h0);
    chk("t4_idle_d3",     32'(idle),          32'h0);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("t4_resp_vld", 32'(bus.resp_valid), 32'(1 << dr_seq[c]));
      chk("t4_ready0",   32'(bus.req_ready),  32'h0);
      chk("t4_idle0",    32'(idle),           32'h0);
      tick();
    end
    chk("t4_idle1",      32'(idle),           32'h1);
    chk("t4_idle_resp",  32'(bus.resp_valid), 32'h0);
    drain = 1'b0;
    #1;
    chk("t4_idle_ready", 32'(bus.req_ready),  32'h0);
    tick();
    chk("t4_resume",     32'(bus.req_ready),  32'h2);
    chk("t4_idle_off",   32'(idle),           32'h0);
    bus.req_valid = 4'b0000;
    tick();

    // Back-to-back MUL (req 1) then ADDC (req 0), rr_ptr = 1
    set_req(0, F_ADDC, 16'hFFFF, 16'h0000, 1'b1);
    set_req(1, F_MUL,  16'h0100, 16'h0100, 1'b0);
    bus.req_valid = 4'b0011;
    #1;
    chk("t5_grant_mul", 32'(bus.req_ready), 32'h2);
    tick();
    #1;
    chk("t5_grant_addc", 32'(bus.req_ready), 32'h1);
    chk("t5_funct_mul",  32'(bus.alu_funct), 32'(F_MUL));
    tick();
    bus.req_valid = 4'b0000;
    chk("t5_funct_addc", 32'(bus.alu_funct), 32'(F_ADDC));
    chk("t5_carry_in",   32'(bus.alu_carry), 32'h1);
    tick();
    tick();
    chk("t5_mul_vld", 32'(bus.resp_valid), 32'h2);
    chk("t5_mul_res", bus.resp_mul,        32'h0001_0000);
    tick();
    chk("t5_addc_vld",   32'(bus.resp_valid),  32'h1);
    chk("t5_addc_res",   32'(bus.resp_result), 32'h0000);
    chk("t5_addc_carry", 32'(bus.resp_carry),  32'h1);
    tick();

    // Reset mid-operation: the stale ALU result must not reach a requester
    set_req(3, F_ADD, 16'h0005, 16'h0006, 1'b0);
    bus.req_valid = 4'b1000;
    #1;
    chk("t6_grant", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0000;
    chk("t6_alu_x", 32'(bus.alu_x), 32'h0005);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rst_alu_x", 32'(bus.alu_x),      32'h0);
    chk("t6_rst_resp",  32'(bus.resp_valid), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_stale_resp", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("t6_stale_err",  32'(err), 32'(EXP_ERR));
    reset = 1'b0;
    #1;
    chk("t6_err_clear",  32'(err), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Spurious alu_valid_out with no tag
    inject = 1'b1;
    #1;
    chk("t7_inject_resp", 32'(bus.resp_valid), 32'h0);
    tick();
    inject = 1'b0;
    chk("t7_err_set",  32'(err), 32'(EXP_ERR));
    tick();
    tick();
    chk("t7_err_held", 32'(err), 32'(EXP_ERR));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one pipelined Manticore ALU (`StandardALUComb`, DSP48-based, fixed latency, `valid_in`/`valid_out`) between `NUM_REQ` requesters. Round-robin grant on a valid/ready request handshake, registered issue into the ALU, and an index pipeline that routes each `valid_out` result back to its issuer. A drain/idle state machine lets the core quiesce the ALU before reconfiguration or reset of neighbours.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ALU_LATENCY`, 3: cycles from ALU `io_valid_in` to `io_valid_out`, ≥1.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester operation valid.
- `req_ready` out NUM_REQ: per-requester accept; a handshake is valid&ready in the same cycle.
- `req_funct` in 4*NUM_REQ: ALU funct per requester, slice i = [4i+3:4i], encoding ADD=0 … ADDC=15.
- `req_x`, `req_y`, `req_mask` in 16*NUM_REQ: operands and mask per requester.
- `req_carry`, `req_select` in NUM_REQ: carry-in and mux select per requester.
- `alu_x`, `alu_y`, `alu_mask` out 16; `alu_funct` out 4; `alu_carry`, `alu_select`, `alu_valid_in` out 1: registered ALU drive.
- `alu_out` in 16; `alu_mul_out` in 32; `alu_carry_out` in 1; `alu_valid_out` in 1: ALU results.
- `resp_valid` out NUM_REQ: one-hot result strobe; no backpressure.
- `resp_result` out 16; `resp_mul` out 32; `resp_carry` out 1: shared result bus, passthrough of ALU outputs.
- `drain` in 1: level request to stop issuing.
- `idle` out 1: high when no operation is in flight and no grant is possible.
- `err` out 1: sticky tag/valid mismatch flag (see Configuration).

## Operation
- FSM states: RUN, DRAIN, IDLE. Reset to RUN.
- RUN: grants to the first asserted `req_valid` at or after `rr_ptr`, wrapping modulo NUM_REQ. `req_ready` is one-hot or zero and combinational from `req_valid`/`rr_ptr`. On a handshake, `rr_ptr` becomes the winner + 1 (mod NUM_REQ). With no handshake, `rr_ptr` holds.
- RUN→DRAIN when `drain`=1. `drain` sampled in RUN forces `req_ready`=0 in that same cycle.
- DRAIN: `req_ready`=0. DRAIN→IDLE when the in-flight count is 0 and the issue register is empty.
- IDLE: `req_ready`=0, `idle`=1. IDLE→RUN when `drain`=0. DRAIN→RUN directly when `drain` deasserts before empty.
- Issue register: on a handshake, the winner's fields load into the `alu_*` registers and `alu_valid_in`=1 the next cycle. Otherwise `alu_valid_in`=0 and the data registers hold.
- Tag pipeline: depth ALU_LATENCY, entries {valid, index[$clog2(NUM_REQ)-1:0]}. It is loaded in step with `alu_valid_in`. The tail entry decodes to `resp_valid` when valid.
- In-flight counter: width $clog2(ALU_LATENCY+2). +1 on handshake, -1 on tail valid. Simultaneous events leave it unchanged.
- `resp_*` buses carry the ALU outputs unmodified. Value is don't-care when `resp_valid`=0.

## Timing
- Latency: handshake at cycle N → `alu_valid_in` at N+1 → `resp_valid[i]` at N+1+ALU_LATENCY.
- Throughput: one operation per cycle, sustained.
- Reset values: `req_ready`=0, all `alu_*`=0, `resp_valid`=0, `idle`=0, `err`=0, `rr_ptr`=0, tags invalid, count 0.
- `reset` asserted mid-operation discards all in-flight tags. ALU results already in flight after reset release produce no `resp_valid` and are flagged by `err` if checking is enabled.

## Configuration
- `ALU_ARB_ERR_CHECK_EN` defined:
  - `err` sets when `alu_valid_out` differs from the tail tag valid.
  - On mismatch, `resp_valid` follows the tag only.
  - `err` clears only on reset.
- Not defined: `err` is tied 0, no comparison logic is built, and `alu_valid_out` is ignored.

## Test plan
- Single op: requester 2 issues ADD 0x1234+0x0001 at cycle 10 → `resp_valid`=4'b0100 at cycle 14 (ALU_LATENCY=3) with `resp_result`=0x1235.
- All four requesters valid continuously from `rr_ptr`=0 → grants 0,1,2,3,0,… one per cycle. Responses return in the same order, each 4 cycles after its grant.
- Requesters 1 and 3 valid, last winner 1 → next grant 3, then 1. Verify no starvation over 100 cycles.
- Assert `drain` with 3 ops in flight → `req_ready`=0 immediately. `idle`=1 one cycle after the third `resp_valid`. Deassert `drain` → RUN, and grants resume the next cycle.
- Back-to-back ADDC 0xFFFF+0x0000+1 → `resp_result`=0x0000, `resp_carry`=1. MUL 0x0100*0x0100 → `resp_mul`=0x00010000.
- With `ALU_ARB_ERR_CHECK_EN`: inject a spurious `alu_valid_out` with no tag → `err`=1 and held. Without the macro, `err` stays 0.
